mirfak_wb_stage: RTL
====================

MIRFAK_WB_STAGE -- requirements
Module: mirfak_wb_stage

Interface
REQ-001 SHALL have parameter none; all sizing SHALL come from the shared defines file.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- wb_pc_i  in  32  PC of the instruction in WB
- wb_pc4_i  in  32  PC+4
- wb_instruction_i  in  32  instruction word
- wb_ex_exception_i  in  1  exception raised upstream
- wb_ex_xcause_i  in  4  upstream cause
- wb_ex_mtval_i  in  32  upstream trap value
- wb_bubble_i  in  1  slot is a bubble
- wb_alu_result_i  in  32  EX result / memory address
- wb_lsu_wdata_i  in  32  store data
- wb_control_i  in  `CTRL_SZ  decoded control
- dwbm_addr_o  out  32  data bus address, word-aligned
- dwbm_dat_o  out  32  write data
- dwbm_sel_o  out  4  byte lanes
- dwbm_cyc_o, dwbm_stb_o, dwbm_we_o  out  1  bus cycle, strobe, write
- dwbm_dat_i  in  32  read data
- dwbm_ack_i, dwbm_err_i  in  1  termination ok / error
- wb_rf_we_o  out  1  register-file write enable
- wb_rf_waddr_o  out  5  rd
- wb_rf_wdata_o  out  32  writeback data, also forwarding source
- wb_exception_o  out  1  trap request
- wb_xcause_o  out  4  trap cause
- wb_mtval_o  out  32  trap value
- wb_retire_o  out  1  instruction retired this cycle
- wb_busy_o  out  1  stall request to pipeline control

Function
REQ-003 A memory op SHALL be `CTRL_MEM_EN && !wb_bubble_i && !wb_ex_exception_i; `CTRL_MEM_RW=1 means store.
REQ-004 FSM states IDLE, ACCESS, DONE: IDLE->ACCESS on memory op without misalignment; ACCESS->DONE on dwbm_ack_i or dwbm_err_i; DONE->IDLE unconditionally.
REQ-005 dwbm_cyc_o/stb_o/we_o/addr_o/dat_o/sel_o SHALL be registered and asserted only in ACCESS; first bus cycle SHALL be the cycle after the op enters WB.
REQ-006 wb_busy_o SHALL be high in IDLE with a non-misaligned memory op and throughout ACCESS; low in DONE and for non-memory instructions.
REQ-007 Pipeline control SHALL advance EX->WB on the first cycle wb_busy_o is low; DONE SHALL last exactly one cycle.
REQ-008 Width from instruction[13:12]: 00 byte, 01 half, 10 word; sel = 0001<<a[1:0], 0011<<{a[1],0}, 1111.
REQ-009 Store data SHALL be lane-replicated: byte x4, half x2, word as is.
REQ-010 Read data SHALL be captured on ack and shifted by a[1:0]; instruction[14]=0 sign-extends, =1 zero-extends.
REQ-011 wb_rf_wdata_o: load data for loads, wb_pc4_i if `CTRL_SEL_PC4, else wb_alu_result_i.
REQ-012 wb_rf_we_o = `CTRL_RF_WE && rd!=0 && !wb_bubble_i && !wb_exception_o && (non-load or DONE).
REQ-013 Exception priority: upstream exception, then misalignment (cause 4 load / 6 store, mtval=address, no bus access), then dwbm_err_i (cause 5 / 7, mtval=address, reported in DONE).
REQ-014 wb_retire_o SHALL pulse once per non-bubble instruction without exception: same cycle for non-memory ops, DONE cycle for memory ops.
REQ-015 ack and err in the same cycle SHALL be treated as err.

Reset
REQ-016 rst_i SHALL force IDLE, all dwbm_* outputs 0, and wb_rf_we_o, wb_exception_o, wb_retire_o, wb_busy_o 0 on the next edge; reset mid-ACCESS SHALL drop cyc/stb immediately with no retire.

Configuration
REQ-017 With MIRFAK_MISALIGN_XCPT_EN defined, REQ-013 misalignment traps SHALL be generated; without it, a[1:0] below access width SHALL be ignored (address forced aligned) and no cause 4/6 SHALL occur.

Structure
REQ-018 `CTRL_MEM_EN, `CTRL_MEM_RW, `CTRL_RF_WE, `CTRL_SEL_PC4, cause codes and FSM encodings SHALL live in mirfak_defines.v.
REQ-019 Bus FSM, lane logic and load formatting SHALL be sub-module mirfak_lsu; writeback mux and exception merge stay in mirfak_wb_stage.

Verification
REQ-020 LW addr 0x100, ack after 2 wait cycles, dat_i 0xDEADBEEF -> sel 1111, busy 3 cycles, rf_wdata 0xDEADBEEF, one retire.
REQ-021 LB addr 0x103, dat_i 0x80FF_FF00 -> sel 1000, rf_wdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-022 SH addr 0x202, wdata 0x1234ABCD -> sel 1100, dat_o 0xABCDABCD, we=1, rf_we=0.
REQ-023 LW addr 0x101 with macro -> no cyc, exception cause 4, mtval 0x101; without macro -> access at 0x100.
REQ-024 SW with dwbm_err_i -> cause 7, mtval=address, no retire; ack+err same cycle -> same result.
REQ-025 rst_i asserted in ACCESS -> cyc/stb 0 next cycle, IDLE, no rf write or retire.

Source files
------------

// File: rtl/mirfak_wb_stage_pkg.sv
// Mirfak writeback stage package: typed views of the shared defines plus
// the byte-lane helpers used by the LSU.
`include "mirfak_defines.v"

package mirfak_wb_stage_pkg;

    localparam int unsigned CTRL_SZ          = `CTRL_SZ;
    localparam int unsigned CTRL_MEM_EN_BIT  = `CTRL_MEM_EN;
    localparam int unsigned CTRL_MEM_RW_BIT  = `CTRL_MEM_RW;
    localparam int unsigned CTRL_RF_WE_BIT   = `CTRL_RF_WE;
    localparam int unsigned CTRL_SEL_PC4_BIT = `CTRL_SEL_PC4;

    localparam logic [3:0] XC_LD_MISALIGN = `XCAUSE_LD_MISALIGN;
    localparam logic [3:0] XC_LD_FAULT    = `XCAUSE_LD_FAULT;
    localparam logic [3:0] XC_ST_MISALIGN = `XCAUSE_ST_MISALIGN;
    localparam logic [3:0] XC_ST_FAULT    = `XCAUSE_ST_FAULT;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    // instruction[13:12]; the unused 11 encoding is treated as a word access
    function automatic mem_size_e decode_size(input logic [1:0] f);
        case (f)
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input mem_size_e sz, input logic [1:0] a);
        case (sz)
            MEM_BYTE: return 4'b0001 << a;
            MEM_HALF: return 4'b0011 << {a[1], 1'b0};
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input mem_size_e sz, input logic [31:0] d);
        case (sz)
            MEM_BYTE: return {4{d[7:0]}};
            MEM_HALF: return {2{d[15:0]}};
            default:  return d;
        endcase
    endfunction

    function automatic logic misaligned(input mem_size_e sz, input logic [1:0] a);
        case (sz)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return a[0];
            default:  return |a;
        endcase
    endfunction

    // Low address bits with the sub-width part cleared
    function automatic logic [1:0] align_low(input mem_size_e sz, input logic [1:0] a);
        case (sz)
            MEM_BYTE: return a;
            MEM_HALF: return {a[1], 1'b0};
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mirfak_defines.v
// Shared sizing, control-field layout, trap cause codes and LSU state
// encodings for the Mirfak writeback stage.
`ifndef MIRFAK_DEFINES_V
`define MIRFAK_DEFINES_V

`define CTRL_SZ             4
`define CTRL_MEM_EN         0
`define CTRL_MEM_RW         1
`define CTRL_RF_WE          2
`define CTRL_SEL_PC4        3

`define XCAUSE_LD_MISALIGN  4'd4
`define XCAUSE_LD_FAULT     4'd5
`define XCAUSE_ST_MISALIGN  4'd6
`define XCAUSE_ST_FAULT     4'd7

`define LSU_ST_IDLE         2'd0
`define LSU_ST_ACCESS       2'd1
`define LSU_ST_DONE         2'd2

`endif

// File: rtl/mirfak_wb_stage_lsu.sv
// Mirfak LSU: data-bus FSM, byte-lane generation and load formatting.
// MIRFAK_MISALIGN_XCPT_EN: flag misaligned accesses instead of aligning them.
`include "mirfak_defines.v"

module mirfak_lsu
    import mirfak_wb_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_op,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        misalign,
    output logic [31:0] load_data
);

    localparam logic [1:0] ST_IDLE   = `LSU_ST_IDLE;
    localparam logic [1:0] ST_ACCESS = `LSU_ST_ACCESS;
    localparam logic [1:0] ST_DONE   = `LSU_ST_DONE;

    logic [1:0]  state;
    mem_size_e   size;
    logic [1:0]  a_lo;
    logic        start;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] shifted;

    assign size = decode_size(funct3[1:0]);

`ifdef MIRFAK_MISALIGN_XCPT_EN
    assign misalign = mem_op && misaligned(size, addr[1:0]);
    assign a_lo     = addr[1:0];
`else
    assign misalign = 1'b0;
    assign a_lo     = align_low(size, addr[1:0]);
`endif

    assign start = mem_op && !misalign;
    assign busy  = ((state == ST_IDLE) && start) || (state == ST_ACCESS);
    assign done  = (state == ST_DONE);
    assign fault = err_q;

    // Bus FSM; bus outputs are registered and only non-zero during ACCESS
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            bus_cyc   <= 1'b0;
            bus_stb   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_sel   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ACCESS;
                        bus_cyc   <= 1'b1;
                        bus_stb   <= 1'b1;
                        bus_we    <= store;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= store_lanes(size, wdata);
                        bus_sel   <= lane_sel(size, a_lo);
                        err_q     <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (bus_ack || bus_err) begin
                        state     <= ST_DONE;
                        bus_cyc   <= 1'b0;
                        bus_stb   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_sel   <= '0;
                        rdata_q   <= bus_rdata;
                        // err wins over a simultaneous ack
                        err_q     <= bus_err;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shift captured read data down to lane 0 and extend per funct3[2]
    always_comb begin
        shifted = rdata_q >> {a_lo, 3'b000};
        case (size)
            MEM_BYTE: load_data = funct3[2] ? {24'b0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            MEM_HALF: load_data = funct3[2] ? {16'b0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default:  load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mirfak_wb_stage.sv
// Mirfak writeback stage: writeback mux, exception merge and retire, with
// memory accesses delegated to mirfak_lsu.
// MIRFAK_MISALIGN_XCPT_EN: enables load/store misalignment traps.
`include "mirfak_defines.v"

module mirfak_wb_stage
    import mirfak_wb_stage_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         wb_pc_i,
    input  logic [31:0]         wb_pc4_i,
    input  logic [31:0]         wb_instruction_i,
    input  logic                wb_ex_exception_i,
    input  logic [3:0]          wb_ex_xcause_i,
    input  logic [31:0]         wb_ex_mtval_i,
    input  logic                wb_bubble_i,
    input  logic [31:0]         wb_alu_result_i,
    input  logic [31:0]         wb_lsu_wdata_i,
    input  logic [`CTRL_SZ-1:0] wb_control_i,
    output logic [31:0]         dwbm_addr_o,
    output logic [31:0]         dwbm_dat_o,
    output logic [3:0]          dwbm_sel_o,
    output logic                dwbm_cyc_o,
    output logic                dwbm_stb_o,
    output logic                dwbm_we_o,
    input  logic [31:0]         dwbm_dat_i,
    input  logic                dwbm_ack_i,
    input  logic                dwbm_err_i,
    output logic                wb_rf_we_o,
    output logic [4:0]          wb_rf_waddr_o,
    output logic [31:0]         wb_rf_wdata_o,
    output logic                wb_exception_o,
    output logic [3:0]          wb_xcause_o,
    output logic [31:0]         wb_mtval_o,
    output logic                wb_retire_o,
    output logic                wb_busy_o
);

    logic        mem_op;
    logic        is_store;
    logic        is_load;
    logic        lsu_busy;
    logic        lsu_done;
    logic        lsu_fault;
    logic        lsu_misalign;
    logic [31:0] load_data;
    logic        xcpt;
    logic        unused_ok;

    assign mem_op   = wb_control_i[CTRL_MEM_EN_BIT] && !wb_bubble_i && !wb_ex_exception_i;
    assign is_store = wb_control_i[CTRL_MEM_RW_BIT];
    assign is_load  = mem_op && !is_store;

    // PC and non-operand instruction bits are not needed at this stage
    assign unused_ok = ^{wb_pc_i, wb_instruction_i[31:15], wb_instruction_i[6:0]};

    mirfak_lsu u_lsu (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .mem_op    (mem_op),
        .store     (is_store),
        .funct3    (wb_instruction_i[14:12]),
        .addr      (wb_alu_result_i),
        .wdata     (wb_lsu_wdata_i),
        .bus_addr  (dwbm_addr_o),
        .bus_wdata (dwbm_dat_o),
        .bus_sel   (dwbm_sel_o),
        .bus_cyc   (dwbm_cyc_o),
        .bus_stb   (dwbm_stb_o),
        .bus_we    (dwbm_we_o),
        .bus_rdata (dwbm_dat_i),
        .bus_ack   (dwbm_ack_i),
        .bus_err   (dwbm_err_i),
        .busy      (lsu_busy),
        .done      (lsu_done),
        .fault     (lsu_fault),
        .misalign  (lsu_misalign),
        .load_data (load_data)
    );

    // Exception merge: upstream trap, then misalignment, then bus error in DONE
    always_comb begin
        xcpt        = 1'b0;
        wb_xcause_o = '0;
        wb_mtval_o  = '0;
        if (wb_ex_exception_i && !wb_bubble_i) begin
            xcpt        = 1'b1;
            wb_xcause_o = wb_ex_xcause_i;
            wb_mtval_o  = wb_ex_mtval_i;
        end else if (lsu_misalign) begin
            xcpt        = 1'b1;
            wb_xcause_o = is_store ? XC_ST_MISALIGN : XC_LD_MISALIGN;
            wb_mtval_o  = wb_alu_result_i;
        end else if (mem_op && lsu_done && lsu_fault) begin
            xcpt        = 1'b1;
            wb_xcause_o = is_store ? XC_ST_FAULT : XC_LD_FAULT;
            wb_mtval_o  = wb_alu_result_i;
        end
    end

    // Writeback data source select
    always_comb begin
        if (is_load)
            wb_rf_wdata_o = load_data;
        else if (wb_control_i[CTRL_SEL_PC4_BIT])
            wb_rf_wdata_o = wb_pc4_i;
        else
            wb_rf_wdata_o = wb_alu_result_i;
    end

    assign wb_rf_waddr_o  = wb_instruction_i[11:7];
    assign wb_exception_o = xcpt && !rst_i;
    assign wb_busy_o      = lsu_busy && !rst_i;
    assign wb_rf_we_o     = !rst_i && wb_control_i[CTRL_RF_WE_BIT] && (wb_rf_waddr_o != 5'd0)
                            && !wb_bubble_i && !xcpt && (!is_load || lsu_done);
    assign wb_retire_o    = !rst_i && !wb_bubble_i && !xcpt && (!mem_op || lsu_done);

endmodule
